// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO command controller.
//   - Address offsets. Each slot decodes at address TOP - OFS_*, where TOP is
//     the all-ones address.
//   - Idle FSM state type.
//   - Bit positions of the STATUS readback word.
//   - Width of the optional command counter (enabled by MMIO_CMD_COUNT_EN).
package mmio_pkg;

  localparam int OFS_CR     = 0;
  localparam int OFS_MM     = 1;
  localparam int OFS_CA     = 2;
  localparam int OFS_RESET  = 3;
  localparam int OFS_IDLE   = 4;
  localparam int OFS_UNIDLE = 5;
  localparam int OFS_STATUS = 6;
  localparam int OFS_COUNT  = 7;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam int STAT_RESET_BIT = 0;
  localparam int STAT_IDLE_BIT  = 1;
  localparam int STAT_ERR_BIT   = 2;

  localparam int CMD_CNT_W = 8;

endpackage

// File: rtl/mmio_pulse_stretch.sv
// mmio_pulse_stretch: a reloadable down-counter that stretches a one-cycle
// load into a pulse RESET_CYCLES clocks long. A load during an active pulse
// restarts the count, so the pulse extends without dropping low.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous, active-high reset
//   load    in   restart the pulse (one-cycle command)
//   active  out  registered pulse, high while the counter is non-zero
module mmio_pulse_stretch #(
  parameter int RESET_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active
);

  localparam int RCNT_W = $clog2(RESET_CYCLES + 1);

  logic [RCNT_W-1:0] cnt;
  logic [RCNT_W-1:0] cnt_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = RCNT_W'(RESET_CYCLES);
    end else if (cnt != '0) begin
      cnt_next = cnt - RCNT_W'(1);
    end
  end

  // active is registered from the next count. It therefore always equals
  // (cnt != 0), and it rises in the cycle right after the load.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      active <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/mmio_ctrl_p.sv
// mmio_ctrl_p: registered memory-mapped command controller for the capture
// engine. The top address slots decode into the following:
//   - one-cycle command strobes (CR, MM, CA)
//   - a stretched soft-reset pulse
//   - a sticky RUN/IDLE state
//   - a STATUS readback
// All outputs are registered. Writes are qualified by in_we.
// Optional build macro MMIO_CMD_COUNT_EN adds an 8-bit saturating count of
// accepted command writes, readable at TOP-7.
//
// Ports:
//   in_clk      in   system clock
//   in_reset    in   asynchronous, active-high reset
//   in_we       in   bus write enable
//   in_re       in   bus read enable
//   in_addr     in   bus address [ADDR_W]
//   out_we_cr   out  strobe, write to TOP
//   out_we_mm   out  strobe, write to TOP-1
//   out_we_ca   out  strobe, write to TOP-2
//   out_reset   out  soft-reset pulse to datapath
//   out_idle    out  1 while in IDLE
//   out_err     out  sticky bus-protocol error (write and read together)
//   out_rdata   out  read data [DATA_W], 0 when out_rvalid is low
//   out_rvalid  out  one-cycle read-data valid
module mmio_ctrl_p #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 8,
  parameter int RESET_CYCLES = 4
) (
  input  logic              in_clk,
  input  logic              in_reset,
  input  logic              in_we,
  input  logic              in_re,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_we_cr,
  output logic              out_we_mm,
  output logic              out_we_ca,
  output logic              out_reset,
  output logic              out_idle,
  output logic              out_err,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_rvalid
);

  import mmio_pkg::*;

  // Because TOP is all ones, TOP - addr is just the bitwise inverse of addr.
  logic [ADDR_W-1:0] ofs;
  assign ofs = ~in_addr;

  logic wr_cr, wr_mm, wr_ca, wr_reset, wr_idle, wr_unidle;
  logic rd, rd_status, proto_err;

  assign wr_cr     = in_we && (ofs == ADDR_W'(OFS_CR));
  assign wr_mm     = in_we && (ofs == ADDR_W'(OFS_MM));
  assign wr_ca     = in_we && (ofs == ADDR_W'(OFS_CA));
  assign wr_reset  = in_we && (ofs == ADDR_W'(OFS_RESET));
  assign wr_idle   = in_we && (ofs == ADDR_W'(OFS_IDLE));
  assign wr_unidle = in_we && (ofs == ADDR_W'(OFS_UNIDLE));

  // A read that collides with a write is dropped and flagged as an error.
  assign rd        = in_re && !in_we;
  assign rd_status = rd && (ofs == ADDR_W'(OFS_STATUS));
  assign proto_err = in_we && in_re;

  mmio_pulse_stretch #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_pulse (
    .clk   (in_clk),
    .rst   (in_reset),
    .load  (wr_reset),
    .active(out_reset)
  );

  // Idle FSM
  state_t state, state_next;
  logic   idle_next;

  always_comb begin
    state_next = state;
    if (wr_reset || wr_unidle) begin
      state_next = ST_RUN;
    end else if (wr_idle) begin
      state_next = ST_IDLE;
    end
    idle_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state    <= ST_RUN;
      out_idle <= 1'b0;
    end else begin
      state    <= state_next;
      out_idle <= idle_next;
    end
  end

`ifdef MMIO_CMD_COUNT_EN
  logic [CMD_CNT_W-1:0] cmd_cnt;
  logic                 wr_cmd;

  assign wr_cmd = wr_cr || wr_mm || wr_ca || wr_idle || wr_unidle;

  // A RESET write clears the count and is itself counted, leaving 1.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      cmd_cnt <= '0;
    end else if (wr_reset) begin
      cmd_cnt <= CMD_CNT_W'(1);
    end else if (wr_cmd && (cmd_cnt != '1)) begin
      cmd_cnt <= cmd_cnt + CMD_CNT_W'(1);
    end
  end
`endif

  // Read data mux. STATUS samples the registered outputs in the read cycle,
  // so it shows the error bit as it was before the clear that the same read
  // causes.
  logic [DATA_W-1:0] rdata_next;

  always_comb begin
    rdata_next = '0;
    if (rd_status) begin
      rdata_next[STAT_RESET_BIT] = out_reset;
      rdata_next[STAT_IDLE_BIT]  = out_idle;
      rdata_next[STAT_ERR_BIT]   = out_err;
    end
`ifdef MMIO_CMD_COUNT_EN
    else if (rd && (ofs == ADDR_W'(OFS_COUNT))) begin
      rdata_next = DATA_W'(cmd_cnt);
    end
`endif
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      out_we_cr  <= 1'b0;
      out_we_mm  <= 1'b0;
      out_we_ca  <= 1'b0;
      out_rvalid <= 1'b0;
      out_rdata  <= '0;
      out_err    <= 1'b0;
    end else begin
      out_we_cr  <= wr_cr;
      out_we_mm  <= wr_mm;
      out_we_ca  <= wr_ca;
      out_rvalid <= rd;
      out_rdata  <= rdata_next;
      // If the error is set and cleared in the same cycle, the set wins.
      if (proto_err) begin
        out_err <= 1'b1;
      end else if (rd_status) begin
        out_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mmio_ctrl_p.md
Name: mmio_ctrl_p

Overview:
- Parametrised, registered memory-mapped I/O controller. It decodes the top slots of the address space into command strobes for the capture engine: control reg, mode/mask, capture arm.
- It also handles a stretched soft-reset pulse, a sticky idle/run state and a status readback.
- It sits between the bus master (soft CPU) and the capture datapath. Unlike the previous generation, writes are qualified by write-enable and all outputs are registered.

Parameters:
- ADDR_W, 7, address width; TOP = 2**ADDR_W-1.
- DATA_W, 8, read-data width (>=3).
- RESET_CYCLES, 4, length of the soft-reset pulse in clocks (>=1).
- RCNT_W, $clog2(RESET_CYCLES+1), pulse counter width (derived, do not override).

Ports:
- in_clk  in  1  system clock
- in_reset  in  1  asynchronous, active-high reset
- in_we  in  1  bus write enable
- in_re  in  1  bus read enable
- in_addr  in  ADDR_W  bus address
- out_we_cr  out  1  one-cycle strobe, write to TOP
- out_we_mm  out  1  one-cycle strobe, write to TOP-1
- out_we_ca  out  1  one-cycle strobe, write to TOP-2
- out_reset  out  1  soft-reset pulse to datapath
- out_idle  out  1  level, 1 while in IDLE state
- out_err  out  1  sticky bus-protocol error
- out_rdata  out  DATA_W  read data
- out_rvalid  out  1  one-cycle read-data valid

Behaviour:
- Interface: one clock (in_clk). Reset in_reset is asynchronous, active-high.
- Reset values: all outputs 0, state RUN, pulse counter 0.
- Address map:
  - TOP=CR, TOP-1=MM, TOP-2=CA
  - TOP-3=RESET, TOP-4=IDLE, TOP-5=UNIDLE
  - TOP-6=STATUS, TOP-7=COUNT (optional feature only)
- Writes:
  - Decoded only when in_we=1. With in_we=0, no strobe, whatever in_addr holds.
  - Strobe outputs go high exactly 1 cycle after the write cycle, for 1 cycle.
  - Back-to-back writes give back-to-back strobes.
  - Writes to unmapped addresses, and to STATUS or COUNT, are ignored silently.
- Soft reset:
  - A write to RESET loads the counter with RESET_CYCLES.
  - out_reset = (counter != 0) as a registered output. It is high from cycle N+1 through N+RESET_CYCLES inclusive, where N is the write cycle.
  - A RESET write during an active pulse reloads the counter; the pulse extends with no glitch low.
  - A RESET write also forces state RUN on the next cycle.
- Idle FSM, states RUN and IDLE:
  - RUN -> IDLE on a write to IDLE.
  - IDLE -> RUN on a write to UNIDLE or RESET.
  - Writing IDLE while IDLE, or UNIDLE while RUN, is a no-op.
  - out_idle is registered and equals (state==IDLE).
  - IDLE/UNIDLE writes are accepted while out_reset is high.
- Reads:
  - in_re=1 with in_we=0 gives out_rvalid=1 on the next cycle.
  - out_rdata for STATUS = {zero-pad, out_err, out_idle, out_reset}, sampled at the read cycle.
  - Other addresses read 0.
  - out_rdata returns to 0 when out_rvalid=0.
  - A STATUS read clears out_err. It takes effect in the same cycle as the rvalid, and rdata shows the pre-clear value.
- Simultaneous events:
  - in_we & in_re in the same cycle: the write executes, the read is dropped (no rvalid), and out_err is set.
  - A set and a clear of out_err in the same cycle: set wins.
- Async reset asserted mid-pulse or mid-read: everything clears immediately, with no strobe or rvalid after deassertion.

Optional Feature:
- Macro: MMIO_CMD_COUNT_EN.
- When defined:
  - 8-bit saturating counter of accepted writes to CR/MM/CA/RESET/IDLE/UNIDLE. It holds at 255.
  - Readable at TOP-7, zero-extended or truncated to DATA_W.
  - Cleared by in_reset or by a RESET command write. The counter ends at 1, counting that write.
- When undefined: no counter logic, and TOP-7 reads 0.

Decomposition:
- Package mmio_pkg holds:
  - address offsets (OFS_CR=0 … OFS_COUNT=7, address = TOP-OFS)
  - state typedef {ST_RUN, ST_IDLE}
  - STATUS bit positions
- One natural sub-module, mmio_pulse_stretch. It is the reloadable down-counter that produces out_reset, parametrised by RESET_CYCLES.

Test Plan (defaults, ADDR_W=7):
- Write addr 127, 126, 125 on consecutive cycles with in_we=1 -> out_we_cr, out_we_mm, out_we_ca each high for one cycle at N+1, N+2, N+3. Repeat with in_we=0 -> no strobes.
- Write 124 at cycle 10 -> out_reset high for cycles 11–14. Write 124 again at cycle 12 -> out_reset stays high through cycle 16.
- Write 123 -> out_idle=1 next cycle. Read 121 -> rdata=8'b010, rvalid for one cycle. Write 124 -> out_idle=0 next cycle.
- Assert in_we=1 and in_re=1 at addr 127 -> cr strobe, no rvalid, out_err=1. Read 121 -> rdata bit2=1, then out_err=0. A second read gives bit2=0.
- Assert in_reset asynchronously while out_reset is high and idle=1 -> all outputs 0 immediately, state RUN after release.
- With MMIO_CMD_COUNT_EN: 300 writes to 127, then read 120 -> rdata=255. Write 124, then read 120 -> 1. Without the macro, reading 120 -> 0.
